// File: rtl/ram_arb_pkg.sv
// Shared types for the data-RAM arbiter: ownership states, port index, lock bound default.
package ram_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} arb_state_t;
  typedef logic port_t;
  localparam int MAX_LOCK_DEF = 16;
endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select for the two RAM requesters.
// RAM_ARB_RR_EN selects round-robin on contention; otherwise port 0 has fixed priority.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      last,
  input  arb_state_t state,
  output logic [1:0] gnt
);
`ifndef RAM_ARB_RR_EN
  logic unused_last;
  assign unused_last = last;
`endif

  always_comb begin
    gnt = 2'b00;
    case (state)
      OWN0:    gnt[0] = req[0];
      OWN1:    gnt[1] = req[1];
      default: begin
        case (req)
          2'b01:   gnt = 2'b01;
          2'b10:   gnt = 2'b10;
`ifdef RAM_ARB_RR_EN
          2'b11:   gnt = last ? 2'b01 : 2'b10;
`else
          2'b11:   gnt = 2'b01;
`endif
          default: gnt = 2'b00;
        endcase
      end
    endcase
  end
endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-port data RAM between the LSU (port 0) and loader/debug (port 1).
// Contention policy set by RAM_ARB_RR_EN (round-robin) or fixed priority when undefined.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int TAM_POSICIONES = 1024,
  parameter int TAM_PALABRA    = 32,
  parameter int MAX_LOCK       = MAX_LOCK_DEF,
  localparam int AW            = $clog2(TAM_POSICIONES)
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   REQ0,
  input  logic                   REQ1,
  input  logic                   WE0,
  input  logic                   WE1,
  input  logic                   LOCK0,
  input  logic                   LOCK1,
  input  logic [AW-1:0]          ADDR0,
  input  logic [AW-1:0]          ADDR1,
  input  logic [TAM_PALABRA-1:0] WDATA0,
  input  logic [TAM_PALABRA-1:0] WDATA1,
  output logic                   GNT0,
  output logic                   GNT1,
  output logic                   RVALID0,
  output logic                   RVALID1,
  output logic [TAM_PALABRA-1:0] RDATA0,
  output logic [TAM_PALABRA-1:0] RDATA1,
  output logic                   RAM_WRITE,
  output logic                   RAM_READ,
  output logic [AW-1:0]          RAM_ADDRESS,
  output logic [TAM_PALABRA-1:0] RAM_DATA_IN,
  input  logic [TAM_PALABRA-1:0] RAM_DATA_OUT
);
  localparam int LW = $clog2(MAX_LOCK + 1);
  localparam logic [LW-1:0] LCNT_LAST = LW'(MAX_LOCK - 1);

  arb_state_t    state, state_n;
  port_t         last, last_n;
  logic [LW-1:0] lcnt, lcnt_n;
  logic [1:0]    gnt_raw, gnt;
  port_t         win;
  logic          any, we, lock;

  ram_arb_pick u_pick (
    .req   ({REQ1, REQ0}),
    .last  (last),
    .state (state),
    .gnt   (gnt_raw)
  );

  // Reset gates the grant so nothing reaches the RAM while RESET_N is low.
  assign gnt  = RESET_N ? gnt_raw : 2'b00;
  assign GNT0 = gnt[0];
  assign GNT1 = gnt[1];
  assign any  = |gnt;
  assign win  = gnt[1];
  assign we   = win ? WE1 : WE0;
  assign lock = win ? LOCK1 : LOCK0;

  assign RAM_WRITE   = any & we;
  assign RAM_READ    = any & ~we;
  assign RAM_ADDRESS = any ? (win ? ADDR1 : ADDR0) : '0;
  assign RAM_DATA_IN = any ? (win ? WDATA1 : WDATA0) : '0;

  always_comb begin
    state_n = state;
    lcnt_n  = lcnt;
    last_n  = last;
    if (any) begin
      last_n = win;
      // The MAX_LOCK-th consecutive locked grant hands the RAM back to arbitration.
      if (lock && lcnt != LCNT_LAST) begin
        state_n = win ? OWN1 : OWN0;
        lcnt_n  = lcnt + 1'b1;
      end else begin
        state_n = IDLE;
        lcnt_n  = '0;
      end
    end else if ((state == OWN0 && !LOCK0) || (state == OWN1 && !LOCK1)) begin
      state_n = IDLE;
      lcnt_n  = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      last  <= 1'b1;
      lcnt  <= '0;
    end else begin
      state <= state_n;
      last  <= last_n;
      lcnt  <= lcnt_n;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      RVALID0 <= 1'b0;
      RVALID1 <= 1'b0;
      RDATA0  <= '0;
      RDATA1  <= '0;
    end else begin
      RVALID0 <= gnt[0] & ~WE0;
      RVALID1 <= gnt[1] & ~WE1;
      if (gnt[0] & ~WE0) RDATA0 <= RAM_DATA_OUT;
      if (gnt[1] & ~WE1) RDATA1 <= RAM_DATA_OUT;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural RAM.
module tb_ram_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          CLK = 1'b0, RESET_N;
  logic          REQ0, REQ1, WE0, WE1, LOCK0, LOCK1;
  logic [AW-1:0] ADDR0, ADDR1;
  logic [DW-1:0] WDATA0, WDATA1;
  logic          GNT0, GNT1, RVALID0, RVALID1;
  logic [DW-1:0] RDATA0, RDATA1;
  logic          RAM_WRITE, RAM_READ;
  logic [AW-1:0] RAM_ADDRESS;
  logic [DW-1:0] RAM_DATA_IN, RAM_DATA_OUT;

  logic [DW-1:0] mem [0:1023];
  int n_cmp = 0, n_bad = 0;

  always #5 CLK = ~CLK;

  ram_arbiter #(.TAM_POSICIONES(1024), .TAM_PALABRA(DW), .MAX_LOCK(16)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1), .LOCK0(LOCK0), .LOCK1(LOCK1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
    .RDATA0(RDATA0), .RDATA1(RDATA1),
    .RAM_WRITE(RAM_WRITE), .RAM_READ(RAM_READ), .RAM_ADDRESS(RAM_ADDRESS),
    .RAM_DATA_IN(RAM_DATA_IN), .RAM_DATA_OUT(RAM_DATA_OUT)
  );

  assign RAM_DATA_OUT = mem[RAM_ADDRESS];
  always @(posedge CLK) if (RAM_WRITE) mem[RAM_ADDRESS] <= RAM_DATA_IN;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    REQ0 = 0; REQ1 = 0; WE0 = 0; WE1 = 0; LOCK0 = 0; LOCK1 = 0;
    ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_g0;
    logic       prev;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;
    idle_inputs();
    RESET_N = 0;

    // Reset holds everything off even with a write request present.
    #3; REQ0 = 1; WE0 = 1; ADDR0 = 10'd5; WDATA0 = 32'h1234_5678;
    #4;
    chk("rst_gnt0", GNT0, 0);
    chk("rst_ram_write", RAM_WRITE, 0);
    chk("rst_rvalid0", RVALID0, 0);
    chk("rst_rvalid1", RVALID1, 0);
    chk("rst_rdata0", RDATA0, 0);
    @(negedge CLK); idle_inputs(); RESET_N = 1;

    // Contention, no lock: reads of 10 (port 0) and 20 (port 1).
`ifdef RAM_ARB_RR_EN
    exp_g0 = 4'b0101;  // bit i = port 0 wins cycle i: 0,1,0,1
`else
    exp_g0 = 4'b1111;
`endif
    @(negedge CLK);
    REQ0 = 1; REQ1 = 1; ADDR0 = 10'd10; ADDR1 = 10'd20;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge CLK);
      #1;
      chk($sformatf("cont_gnt0_%0d", i), GNT0, exp_g0[i]);
      chk($sformatf("cont_gnt1_%0d", i), GNT1, !exp_g0[i]);
      chk($sformatf("cont_addr_%0d", i), RAM_ADDRESS, exp_g0[i] ? 10 : 20);
      if (i > 0) begin
        chk($sformatf("cont_rv0_%0d", i), RVALID0, prev);
        chk($sformatf("cont_rv1_%0d", i), RVALID1, !prev);
      end
      prev = exp_g0[i];
    end
    @(negedge CLK); idle_inputs(); #1;
    chk("cont_rv_last", prev ? RVALID0 : RVALID1, 1);
    chk("cont_rdata_last", prev ? RDATA0 : RDATA1, prev ? 32'hA000_000A : 32'hA000_0014);
    chk("cont_idle_gnt", {GNT1, GNT0}, 2'b00);

    // Single write then read-back on port 0.
    @(negedge CLK);
    REQ0 = 1; WE0 = 1; ADDR0 = 10'd5; WDATA0 = 32'hDEAD_BEEF; #1;
    chk("wr_gnt0", GNT0, 1);
    chk("wr_ram_write", RAM_WRITE, 1);
    chk("wr_ram_read", RAM_READ, 0);
    chk("wr_ram_addr", RAM_ADDRESS, 5);
    chk("wr_ram_din", RAM_DATA_IN, 32'hDEAD_BEEF);
    @(negedge CLK); WE0 = 0; #1;
    chk("rd_gnt0", GNT0, 1);
    chk("rd_ram_read", RAM_READ, 1);
    chk("rd_rv0_after_wr", RVALID0, 0);
    @(negedge CLK); idle_inputs(); #1;
    chk("rd_rv0", RVALID0, 1);
    chk("rd_rdata0", RDATA0, 32'hDEAD_BEEF);
    chk("idle_ram_addr", RAM_ADDRESS, 0);
    chk("idle_ram_din", RAM_DATA_IN, 0);
    chk("idle_ram_read", RAM_READ, 0);
    @(negedge CLK); #1;
    chk("rd_rv0_one_cycle", RVALID0, 0);
    chk("rd_rdata0_hold", RDATA0, 32'hDEAD_BEEF);

    // Port 1 locks and reads 0..3; port 0 stalls; one locked idle cycle in the middle.
    @(negedge CLK);
    REQ1 = 1; LOCK1 = 1; ADDR1 = 10'd0; ADDR0 = 10'd7; #1;
    chk("lk_gnt1_0", GNT1, 1);
    for (int k = 1; k < 4; k++) begin
      @(negedge CLK); REQ0 = 1; ADDR1 = AW'(k); REQ1 = 1;
      if (k == 3) LOCK1 = 0;
      #1;
      chk($sformatf("lk_gnt1_%0d", k), GNT1, 1);
      chk($sformatf("lk_gnt0_%0d", k), GNT0, 0);
      chk($sformatf("lk_rdata1_%0d", k), RDATA1, 32'hA000_0000 + k - 1);
      if (k == 2) begin
        @(negedge CLK); REQ1 = 0; #1;
        chk("lk_hold_gnt", {GNT1, GNT0}, 2'b00);
      end
    end
    @(negedge CLK); REQ1 = 0; #1;
    chk("lk_release_gnt0", GNT0, 1);
    chk("lk_rv1", RVALID1, 1);
    chk("lk_rdata1_3", RDATA1, 32'hA000_0003);
    @(negedge CLK); idle_inputs(); #1;
    chk("lk_rdata0", RDATA0, 32'hA000_0007);
    chk("lk_rv1_clear", RVALID1, 0);

    // Lock bound: port 0 holds LOCK0 for 16 grants while port 1 waits.
    @(negedge CLK);
    REQ0 = 1; LOCK0 = 1; ADDR0 = 10'd0; ADDR1 = 10'd30; #1;
    chk("bnd_gnt0_0", GNT0, 1);
    for (int k = 1; k < 16; k++) begin
      @(negedge CLK); REQ1 = 1; ADDR0 = AW'(k); #1;
      chk($sformatf("bnd_gnt0_%0d", k), GNT0, 1);
      chk($sformatf("bnd_gnt1_%0d", k), GNT1, 0);
    end
    @(negedge CLK); #1;
`ifdef RAM_ARB_RR_EN
    chk("bnd_gnt1_17", GNT1, 1);
    chk("bnd_gnt0_17", GNT0, 0);
`else
    chk("bnd_gnt0_17", GNT0, 1);
    chk("bnd_gnt1_17", GNT1, 0);
`endif
    @(negedge CLK); idle_inputs(); #1;
    chk("bnd_idle", {GNT1, GNT0}, 2'b00);

    // Reset pulsed between a port-1 read grant and its edge.
    @(negedge CLK);
    REQ1 = 1; ADDR1 = 10'd9; #1;
    chk("mr_gnt1", GNT1, 1);
    #2; RESET_N = 0; #1;
    chk("mr_gnt1_in_rst", GNT1, 0);
    chk("mr_ram_read_in_rst", RAM_READ, 0);
    @(negedge CLK); #1;
    chk("mr_rv1", RVALID1, 0);
    chk("mr_rdata1", RDATA1, 0);
    RESET_N = 1; REQ1 = 0; REQ0 = 1; ADDR0 = 10'd2; #1;
    chk("mr_idle_gnt0", GNT0, 1);
    @(negedge CLK); idle_inputs(); #1;
    chk("mr_rdata0", RDATA0, 32'hA000_0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
